// File: rtl/lcd_controller.sv
// HD44780-class character LCD controller: power-up init, command/data FIFO, timed panel writes.
// Defining LCD_IRQ_EN adds the irq output and the CTRL bit3 irq enable.
module lcd_controller #(
  parameter int unsigned TICK_W       = 20,
  parameter int unsigned POWERUP_WAIT = 750000,
  parameter int unsigned SETUP        = 4,
  parameter int unsigned E_PULSE      = 16,
  parameter int unsigned CMD_WAIT     = 2000,
  parameter int unsigned CLEAR_WAIT   = 82000,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  input  logic [3:0]  be,
  output logic [31:0] readdata,
  output logic        lcd_e,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
`ifdef LCD_IRQ_EN
  output logic        lcd_on,
  output logic        irq
`else
  output logic        lcd_on
`endif
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StPowerup, StLoad, StSetup, StPulse, StWait, StIdle} state_e;
  state_e state_q, state_d;

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [8:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [3:0]        init_idx_q;
  logic              init_done_q, overflow_q, lcd_on_q, rs_q;
  logic [7:0]        data_q;
  logic [31:0]       readdata_q, status, ctrl_rd;
  logic              push, push_ok, ctrl_wr, flush, full, empty, pop, busy, phase_done, long_wait;
  logic              unused_bits;

  assign push       = write && be[0] && (address == 2'd0 || address == 2'd1);
  assign ctrl_wr    = write && be[0] && address == 2'd3;
  assign flush      = ctrl_wr && writedata[1];
  assign full       = count_q == CW'(FIFO_DEPTH);
  assign empty      = count_q == '0;
  assign push_ok    = push && !full;
  assign phase_done = cnt_q == '0;
  // Clear and home need the long post-write wait
  assign long_wait  = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign unused_bits = ^{writedata[31:8], be[3:1]};

  function automatic logic [7:0] init_byte(logic [2:0] idx);
    case (idx)
      3'd4:    return 8'h08;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      3'd7:    return 8'h0C;
      default: return 8'h3C;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StPowerup;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = phase_done ? cnt_q : cnt_q - TICK_W'(1);
    unique case (state_q)
      StPowerup: if (phase_done) state_d = StLoad;
      StLoad: begin
        state_d = StSetup;
        cnt_d   = TICK_W'(SETUP - 1);
      end
      StSetup: if (phase_done) begin
        state_d = StPulse;
        cnt_d   = TICK_W'(E_PULSE - 1);
      end
      StPulse: if (phase_done) begin
        state_d = StWait;
        cnt_d   = long_wait ? TICK_W'(CLEAR_WAIT - 1) : TICK_W'(CMD_WAIT - 1);
      end
      StWait: if (phase_done) begin
        state_d = (init_done_q || init_idx_q == 4'd8) ? StIdle : StLoad;
      end
      StIdle: if (!empty) begin
        state_d = StSetup;
        cnt_d   = TICK_W'(SETUP - 1);
      end
      default: state_d = StPowerup;
    endcase
  end

  always_comb begin
    lcd_e = state_q == StPulse;
    busy  = state_q != StIdle;
    pop   = state_q == StIdle && !empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= TICK_W'(POWERUP_WAIT - 1);
      data_q      <= '0;
      rs_q        <= 1'b0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == StLoad) begin
        data_q     <= init_byte(init_idx_q[2:0]);
        rs_q       <= 1'b0;
        init_idx_q <= init_idx_q + 4'd1;
      end else if (pop) begin
        {rs_q, data_q} <= fifo_mem[rd_ptr_q];
      end
      if (state_q == StWait && phase_done && init_idx_q == 4'd8) init_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {address[0], writedata[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      lcd_on_q   <= 1'b0;
    end else begin
      if (push && full)                 overflow_q <= 1'b1;
      else if (ctrl_wr && writedata[2]) overflow_q <= 1'b0;
      if (ctrl_wr) lcd_on_q <= writedata[0];
    end
  end

`ifdef LCD_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[3];
      irq_q <= init_done_q && empty && state_q == StIdle && irq_en_q;
    end
  end
  assign irq     = irq_q;
  assign ctrl_rd = {28'b0, irq_en_q, 2'b0, lcd_on_q};
`else
  assign ctrl_rd = {31'b0, lcd_on_q};
`endif

  assign status = {16'b0, 8'(count_q), 3'b0, empty, overflow_q, full, busy, init_done_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= '0;
    end else if (read) begin
      case (address)
        2'd2:    readdata_q <= status;
        2'd3:    readdata_q <= ctrl_rd;
        default: readdata_q <= '0;
      endcase
    end
  end

  assign readdata = readdata_q;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = lcd_on_q;
endmodule
